// File: rtl/path_meas_pkg.sv
// Shared types and default sizes for the delay-path launch/capture controller.
package path_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESET,
    LAUNCH,
    WAIT,
    SYNC,
    CHECK,
    FINISH
  } state_t;

  localparam int DEF_DLY_W  = 8;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_SETTLE = 16;

  // Width of a down-counter that must hold n-1.
  function automatic int cnt_w_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/path_launch_capture_if.sv
// Control/status and path connections of the launch/capture controller.
interface path_launch_capture_if #(
  parameter int DLY_W = path_meas_pkg::DEF_DLY_W,
  parameter int CNT_W = path_meas_pkg::DEF_CNT_W
);
  logic             start;
  logic [DLY_W-1:0] sample_delay;
  logic [CNT_W-1:0] num_trials;
  logic             path_in;
  logic             path_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic             last_sample;

  modport master (
    output start, sample_delay, num_trials, path_out,
    input  path_in, busy, done, err_count, last_sample
  );

  modport slave (
    input  start, sample_delay, num_trials, path_out,
    output path_in, busy, done, err_count, last_sample
  );
endinterface

// File: rtl/path_capture_sync.sv
// Enabled capture flop at the chain end followed by a stabilising re-register.
module path_capture_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_cap_en,
  input  logic i_sync_en,
  input  logic i_path_out,
  output logic o_sample
);
  (* keep = "true", dont_touch = "true" *) logic r_cap_p0;
  (* keep = "true", dont_touch = "true" *) logic r_sync_p1;

  // Capture stage: may go metastable, never compared directly.
  always_ff @(posedge clk) begin
    if (i_cap_en) r_cap_p0 <= i_path_out;
  end

  // Stabilising stage.
  always_ff @(posedge clk) begin
    if (rst)            r_sync_p1 <= 1'b0;
    else if (i_sync_en) r_sync_p1 <= r_cap_p0;
  end

  assign o_sample = r_sync_p1;
endmodule

// File: rtl/path_launch_capture.sv
// Repeatedly launches an edge into a delay chain and counts late captures at its end.
module path_launch_capture
  import path_meas_pkg::*;
#(
  parameter int DLY_W        = DEF_DLY_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int SETTLE       = DEF_SETTLE,
  parameter int PATH_INVERTS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  path_launch_capture_if.slave bus
);
  localparam int   SET_W = cnt_w_for(SETTLE);
  localparam logic INV   = (PATH_INVERTS != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DLY_W-1:0] r_dly_lat;
  logic [DLY_W-1:0] r_dly_cnt;
  logic [CNT_W-1:0] r_trials_lat;
  logic [CNT_W-1:0] r_trial_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] w_trial_inc;
  logic [SET_W-1:0] r_settle_cnt;
  logic             r_pol;
  (* keep = "true", dont_touch = "true" *) logic r_path_in;
  logic             w_busy;
  logic             w_done;
  logic             w_cap_en;
  logic             w_sync_en;
  logic             w_last_sample;
  logic             w_expected;
  logic             w_accept;
  logic             w_enter_preset;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept       = (r_state == IDLE) && bus.start;
  assign w_trial_inc    = r_trial_cnt + CNT_W'(1);
  assign w_expected     = ~r_pol ^ INV;
  assign w_enter_preset = (w_state_nxt == PRESET) && (r_state != PRESET);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_cap_en    = 1'b0;
    w_sync_en   = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_accept) w_state_nxt = (bus.num_trials == '0) ? FINISH : PRESET;
      end
      PRESET: if (r_settle_cnt == '0) w_state_nxt = LAUNCH;
      LAUNCH: w_state_nxt = WAIT;
      WAIT: begin
        if (r_dly_cnt == '0) begin
          w_cap_en    = 1'b1;
          w_state_nxt = SYNC;
        end
      end
      SYNC: begin
        w_sync_en   = 1'b1;
        w_state_nxt = CHECK;
      end
      CHECK: w_state_nxt = (w_trial_inc == r_trials_lat) ? FINISH : PRESET;
      FINISH: begin
        w_busy      = 1'b0;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Launch flop and run bookkeeping; path_in is parked at pol before PRESET starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_path_in   <= 1'b0;
      r_pol       <= 1'b0;
      r_trial_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pol       <= 1'b0;
            r_trial_cnt <= '0;
            r_err_cnt   <= '0;
            if (bus.num_trials != '0) r_path_in <= 1'b0;
          end
        end
        LAUNCH: r_path_in <= ~r_pol;
        CHECK: begin
          if (w_last_sample != w_expected) r_err_cnt <= sat_inc(r_err_cnt);
          r_trial_cnt <= w_trial_inc;
          r_pol       <= ~r_pol;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dly_lat    <= bus.sample_delay;
      r_trials_lat <= bus.num_trials;
    end
    if (w_enter_preset)           r_settle_cnt <= SET_W'(SETTLE - 1);
    else if (r_settle_cnt != '0)  r_settle_cnt <= r_settle_cnt - SET_W'(1);
    if (r_state == LAUNCH)        r_dly_cnt <= r_dly_lat;
    else if (r_dly_cnt != '0)     r_dly_cnt <= r_dly_cnt - DLY_W'(1);
  end

  path_capture_sync u_capture (
    .clk        (clk),
    .rst        (rst),
    .i_cap_en   (w_cap_en),
    .i_sync_en  (w_sync_en),
    .i_path_out (bus.path_out),
    .o_sample   (w_last_sample)
  );

  assign bus.path_in     = r_path_in;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.err_count   = r_err_cnt;
  assign bus.last_sample = w_last_sample;
endmodule

// File: tb/tb_path_launch_capture.sv
// Scoreboard bench: three controllers around modelled chains (plain/3-cycle, inverting, 50-cycle).
module tb_path_launch_capture;
  localparam int SET = 16;

  typedef struct {
    int err;
    int lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  path_launch_capture_if #(.DLY_W(8), .CNT_W(16)) ifa ();
  path_launch_capture_if #(.DLY_W(8), .CNT_W(16)) ifb ();
  path_launch_capture_if #(.DLY_W(8), .CNT_W(4))  ifc ();

  path_launch_capture #(.DLY_W(8), .CNT_W(16), .SETTLE(SET), .PATH_INVERTS(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  path_launch_capture #(.DLY_W(8), .CNT_W(16), .SETTLE(SET), .PATH_INVERTS(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  path_launch_capture #(.DLY_W(8), .CNT_W(4), .SETTLE(SET), .PATH_INVERTS(0))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // Chain models: shift registers of path_in, tap k-1 gives a k-cycle delay.
  logic [63:0] sh_a, sh_b, sh_c;
  int          a_mode;
  always @(posedge clk) begin
    if (rst) begin
      sh_a <= '0;
      sh_b <= '0;
      sh_c <= '0;
    end else begin
      sh_a <= {sh_a[62:0], ifa.path_in};
      sh_b <= {sh_b[62:0], ifb.path_in};
      sh_c <= {sh_c[62:0], ifc.path_in};
    end
  end
  assign ifa.path_out = (a_mode == 0) ? ifa.path_in : sh_a[2];
  assign ifb.path_out = ~sh_b[0];
  assign ifc.path_out = sh_c[49];

  logic done_v [3];
  logic busy_v [3];
  logic pin_v  [3];
  logic ls_v   [3];
  int   err_v  [3];
  assign done_v[0] = ifa.done;  assign done_v[1] = ifb.done;  assign done_v[2] = ifc.done;
  assign busy_v[0] = ifa.busy;  assign busy_v[1] = ifb.busy;  assign busy_v[2] = ifc.busy;
  assign pin_v[0]  = ifa.path_in; assign pin_v[1] = ifb.path_in; assign pin_v[2] = ifc.path_in;
  assign ls_v[0]   = ifa.last_sample; assign ls_v[1] = ifb.last_sample; assign ls_v[2] = ifc.last_sample;
  assign err_v[0]  = int'(ifa.err_count);
  assign err_v[1]  = int'(ifb.err_count);
  assign err_v[2]  = int'(ifc.err_count);

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   t_start [3];
  int   ndone   [3];
  int   trans_b[$];
  bit   rec_b;
  logic prev_pin_b;

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic score(input int i, input bit have, input exp_t e);
    check($sformatf("dut%0d_done_expected", i), int'(have), 1);
    if (have) begin
      check($sformatf("dut%0d_err_count", i), err_v[i], e.err);
      check($sformatf("dut%0d_done_latency", i), cyc - t_start[i], e.lat);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    bit   have;
    prev_pin_b = 1'b0;
    forever begin
      @(negedge clk);
      if (done_v[0] === 1'b1) begin
        ndone[0]++;
        have = (q0.size() != 0);
        if (have) e = q0.pop_front();
        score(0, have, e);
      end
      if (done_v[1] === 1'b1) begin
        ndone[1]++;
        have = (q1.size() != 0);
        if (have) e = q1.pop_front();
        score(1, have, e);
      end
      if (done_v[2] === 1'b1) begin
        ndone[2]++;
        have = (q2.size() != 0);
        if (have) e = q2.pop_front();
        score(2, have, e);
      end
      if (rec_b && (pin_v[1] != prev_pin_b)) trans_b.push_back(int'(pin_v[1]));
      prev_pin_b = pin_v[1];
    end
  end

  task automatic run(input int sel, input int dly, input int n, input int eerr, input int elat);
    exp_t e;
    e.err = eerr;
    e.lat = elat;
    @(negedge clk);
    case (sel)
      0: begin
        ifa.sample_delay = 8'(dly); ifa.num_trials = 16'(n); ifa.start = 1'b1; q0.push_back(e);
      end
      1: begin
        ifb.sample_delay = 8'(dly); ifb.num_trials = 16'(n); ifb.start = 1'b1; q1.push_back(e);
      end
      default: begin
        ifc.sample_delay = 8'(dly); ifc.num_trials = 4'(n); ifc.start = 1'b1; q2.push_back(e);
      end
    endcase
    t_start[sel] = cyc;
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int budget, output int busy_low);
    int got;
    got      = 0;
    busy_low = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_v[sel] === 1'b1) begin
        got = 1;
        break;
      end
      if (busy_v[sel] !== 1'b1) busy_low++;
      @(negedge clk);
    end
    check($sformatf("dut%0d_done_within_budget", sel), got, 1);
  endtask

  initial begin
    int   bl;
    int   nd;
    int   trans_exp [4];
    trans_exp = '{1, 0, 1, 0};
    rst = 1'b1;
    a_mode = 0;
    rec_b = 1'b0;
    ifa.start = 1'b0; ifa.sample_delay = '0; ifa.num_trials = '0;
    ifb.start = 1'b0; ifb.sample_delay = '0; ifb.num_trials = '0;
    ifc.start = 1'b0; ifc.sample_delay = '0; ifc.num_trials = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d_rst_busy", i), int'(busy_v[i]), 0);
      check($sformatf("dut%0d_rst_done", i), int'(done_v[i]), 0);
      check($sformatf("dut%0d_rst_path_in", i), int'(pin_v[i]), 0);
      check($sformatf("dut%0d_rst_err", i), err_v[i], 0);
      check($sformatf("dut%0d_rst_last_sample", i), int'(ls_v[i]), 0);
    end
    rst = 1'b0;

    // Zero-delay chain, 1-cycle window: 10*(16+4)+1.
    a_mode = 0;
    run(0, 0, 10, 0, 201);
    wait_done(0, 400, bl);
    check("a_zero_delay_busy_low_cycles", bl, 0);
    check("a_zero_delay_last_sample", int'(ls_v[0]), 0);

    // 3-cycle chain: window 2 fails every trial, window 4 passes.
    a_mode = 1;
    run(0, 1, 8, 8, 169);
    wait_done(0, 400, bl);
    check("a_short_window_last_sample", int'(ls_v[0]), 1);
    run(0, 3, 8, 0, 185);
    wait_done(0, 400, bl);
    check("a_exact_window_last_sample", int'(ls_v[0]), 0);

    // Inverting 1-cycle chain, launch polarity must alternate 1,0,1,0.
    rec_b = 1'b1;
    run(1, 2, 4, 0, 89);
    wait_done(1, 200, bl);
    rec_b = 1'b0;
    check("b_launch_transitions", trans_b.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("b_launch_value%0d", i), (i < trans_b.size()) ? trans_b[i] : -1, trans_exp[i]);
    check("b_last_sample", int'(ls_v[1]), 1);

    // 50-cycle chain always late; 4-bit counter tops out; mid-run start ignored.
    run(2, 20, 15, 15, 601);
    nd = ndone[2];
    repeat (100) @(negedge clk);
    ifc.num_trials = 4'd3;
    ifc.sample_delay = 8'd0;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(2, 700, bl);
    check("c_busy_low_cycles", bl, 0);
    repeat (40) @(negedge clk);
    check("c_done_pulse_count", ndone[2] - nd, 1);

    // Zero trials: done next cycle, err cleared, path_in untouched.
    check("c_path_in_before_zero_run", int'(pin_v[2]), 1);
    run(2, 0, 0, 0, 1);
    wait_done(2, 10, bl);
    check("c_zero_run_path_in", int'(pin_v[2]), 1);

    // Reset during WAIT of the third trial.
    a_mode = 0;
    run(0, 3, 5, 0, 116);
    while (cyc < t_start[0] + 64) @(negedge clk);
    check("a_path_in_before_abort", int'(pin_v[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check("a_abort_busy", int'(busy_v[0]), 0);
    check("a_abort_done", int'(done_v[0]), 0);
    check("a_abort_path_in", int'(pin_v[0]), 0);
    rst = 1'b0;
    q0.delete();
    nd = ndone[0];
    repeat (150) @(negedge clk);
    check("a_abort_no_done", ndone[0] - nd, 0);

    // start together with rst: reset wins.
    rst = 1'b1;
    ifa.start = 1'b1;
    ifa.num_trials = 16'd2;
    @(negedge clk);
    rst = 1'b0;
    ifa.start = 1'b0;
    check("a_rst_start_busy", int'(busy_v[0]), 0);
    @(negedge clk);
    check("a_rst_start_busy_next", int'(busy_v[0]), 0);

    // Fresh run after the abort.
    run(0, 0, 3, 0, 61);
    wait_done(0, 200, bl);
    check("a_fresh_busy_low_cycles", bl, 0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time actual 300000 required below 300000");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/path_launch_capture.md
Name: path_launch_capture

Overview:
- Launch/capture controller that drives the input of a chained delay path and samples its output.
- Sits directly around the chained spy path: path_in feeds the chain's pathInput, and the chain's pathResult returns on path_out.
- Per trial, it presets the path, toggles the launch flop, and enables the capture flop a programmable number of cycles later.
- Across N trials it counts samples that do not match the settled value, which measures whether the path delay exceeds the sampling window.

Parameters:
- DLY_W, 8, width of sample_delay (cycles between launch and capture).
- CNT_W, 16, width of num_trials and err_count.
- SETTLE, 16, cycles path_in is held at the preset value before launch (must be ≥ worst-case path delay).
- PATH_INVERTS, 0, 1 if the chain has an odd inversion count (path output = NOT input); 0 if even.

Ports:
- clk  in  1  system clock; launch and capture flops share it.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a measurement run; ignored while busy.
- sample_delay  in  DLY_W  launch-to-capture spacing in cycles; latched on accepted start.
- num_trials  in  CNT_W  number of launch/capture trials; latched on accepted start.
- path_in  out  1  launch flop output; drives the chain input.
- path_out  in  1  chain output; asynchronous to launch, sampled only by the capture flop.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a run.
- err_count  out  CNT_W  mismatching samples in the last run; held until the next accepted start.
- last_sample  out  1  most recent stabilised capture value.

Behaviour:
- Reset values (rst sampled high on a clk edge):
  - state=IDLE, path_in=0, busy=0, done=0, err_count=0, last_sample=0.
  - Reset asserted mid-run aborts the run; no done pulse is issued.
- Accepted start: start=1 while in IDLE. On acceptance:
  - latch sample_delay and num_trials;
  - clear err_count, trial counter, and pol (pol=0);
  - go to PRESET.
- num_trials=0: go directly from IDLE to FINISH, giving done one cycle after start with err_count=0.
- PRESET:
  - path_in=pol; hold for SETTLE cycles, then go to LAUNCH.
- LAUNCH (1 cycle):
  - path_in toggles to ~pol at the end of this cycle's edge;
  - load delay counter with sample_delay; go to WAIT.
- WAIT:
  - decrement each cycle;
  - capture enable asserts in the cycle where the counter is 0;
  - the capture flop samples path_out on that edge.
  - sample_delay=0 means capture on the first edge after launch (1-cycle window).
  - Window length is sample_delay+1 clk periods.
- SYNC (1 cycle):
  - the capture flop output is re-registered (second flop) into last_sample; no compare is made on the raw capture flop.
- CHECK (1 cycle):
  - expected = ~pol XOR PATH_INVERTS;
  - if last_sample != expected, increment err_count, saturating at all-ones (no wrap);
  - increment the trial counter and invert pol so rising and falling edges alternate.
  - If trial count == num_trials, go to FINISH; else go to PRESET.
- FINISH:
  - done=1 for one cycle, busy=0; return to IDLE.
  - path_in keeps its last value until the next run.
- Signals that do not affect a run in progress:
  - start while busy: ignored.
  - sample_delay/num_trials changes while busy: no effect.
  - start coincident with rst: reset wins.
- Cycle count per trial: SETTLE + 1 + (sample_delay+1) + 2.
- Attributes: keep/DONT_TOUCH on the launch and capture flops; the capture flop is placed adjacent to the chain end.

Decomposition:
- Shared package (path_meas_pkg):
  - state enum {IDLE, PRESET, LAUNCH, WAIT, SYNC, CHECK, FINISH};
  - default widths DLY_W/CNT_W;
  - SETTLE default.
- One natural sub-module: path_capture_sync, containing the enabled capture flop plus the second stabilising flop, with keep attributes.
- The FSM and counters stay in the top module.

Test Plan:
- Chain modelled as a zero-delay wire, PATH_INVERTS=0, num_trials=10, sample_delay=0 -> done after 10*(SETTLE+4)+1 cycles; err_count=0; busy high throughout.
- Chain modelled as a 3-cycle delay, sample_delay=1, num_trials=8 -> err_count=8; sample_delay=3 -> err_count=0 (boundary: window = delay+1).
- Inverting model (PATH_INVERTS=1, output = NOT of a 1-cycle-delayed input), sample_delay=2, num_trials=4 -> err_count=0; path_in observed to alternate launch polarity 1,0,1,0.
- num_trials=0 -> done pulses one cycle after start, err_count=0, path_in unchanged.
- Overflow/ignore: CNT_W=4, always-failing path (delay 50 cycles), num_trials=15, a second start pulse mid-run -> err_count=15 (saturated, no wrap); second start ignored; exactly one done pulse.
- rst asserted during WAIT of trial 3 -> next edge shows IDLE, path_in=0, busy=0, no done pulse; a fresh start then completes normally.
